// File: rtl/register_file_multiport.sv
// Parametrised general-purpose register bank: one synchronous write port, two
// combinational read ports, post-reset write guard, optional zero register and bypass.
module register_file_multiport #(
    parameter int               WIDTH       = 16,
    parameter int               ADDR_W      = 3,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
    parameter int               INIT_CYCLES = 1,
    parameter bit               ZERO_REG    = 1'b0,
    parameter bit               BYPASS      = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              should_write,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [WIDTH-1:0]  new_value,
    input  logic [ADDR_W-1:0] read_addr_a,
    output logic [WIDTH-1:0]  read_value_a,
    input  logic [ADDR_W-1:0] read_addr_b,
    output logic [WIDTH-1:0]  read_value_b,
    output logic              ready,
    output logic              write_dropped
);
    localparam int               DEPTH      = 2 ** ADDR_W;
    localparam int               CNT_W      = (INIT_CYCLES > 0) ? $clog2(INIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] INIT_LIMIT = CNT_W'(INIT_CYCLES);
    localparam logic             READY_RST  = (INIT_CYCLES == 0) ? 1'b1 : 1'b0;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [CNT_W-1:0] init_cnt_r;
    logic [CNT_W-1:0] init_cnt_next_s;
    logic             ready_r;
    logic             write_dropped_r;
    logic             zero_hit_s;
    logic             accept_s;
    logic [WIDTH-1:0] read_a_s;
    logic [WIDTH-1:0] read_b_s;

    // Guard counter advances once per posedge after reset release and saturates at the limit
    always_comb begin
        init_cnt_next_s = init_cnt_r;
        if (init_cnt_r != INIT_LIMIT) begin
            init_cnt_next_s = init_cnt_r + CNT_W'(1);
        end else begin
            init_cnt_next_s = init_cnt_r;
        end
    end

    // ready is registered from the next counter value so it rises on the Nth posedge
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            init_cnt_r <= {CNT_W{1'b0}};
            ready_r    <= READY_RST;
        end else begin
            init_cnt_r <= init_cnt_next_s;
            ready_r    <= (init_cnt_next_s == INIT_LIMIT);
        end
    end

    // Write acceptance: a write to the hardwired zero entry counts as discarded
    always_comb begin
        zero_hit_s = ZERO_REG && (write_addr == {ADDR_W{1'b0}});
        accept_s   = should_write & ready_r & ~zero_hit_s;
    end

    // Storage array and the one-cycle dropped-request flag
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= RESET_VALUE;
            end
            write_dropped_r <= 1'b0;
        end else begin
            if (accept_s) begin
                mem_r[write_addr] <= new_value;
            end
            write_dropped_r <= should_write & ~accept_s;
        end
    end

    // Read port A: zero entry wins over bypass, bypass wins over stored data
    always_comb begin
        read_a_s = mem_r[read_addr_a];
        if (ZERO_REG && (read_addr_a == {ADDR_W{1'b0}})) begin
            read_a_s = {WIDTH{1'b0}};
        end else if (BYPASS && accept_s && (read_addr_a == write_addr)) begin
            read_a_s = new_value;
        end else begin
            read_a_s = mem_r[read_addr_a];
        end
    end

    // Read port B: same priority as port A, evaluated independently
    always_comb begin
        read_b_s = mem_r[read_addr_b];
        if (ZERO_REG && (read_addr_b == {ADDR_W{1'b0}})) begin
            read_b_s = {WIDTH{1'b0}};
        end else if (BYPASS && accept_s && (read_addr_b == write_addr)) begin
            read_b_s = new_value;
        end else begin
            read_b_s = mem_r[read_addr_b];
        end
    end

    assign read_value_a  = read_a_s;
    assign read_value_b  = read_b_s;
    assign ready         = ready_r;
    assign write_dropped = write_dropped_r;
endmodule

// File: tb/tb_register_file_multiport.sv
// Bench for register_file_multiport: three configurations driven side by side, checked
// by directed vectors, hand sequences and a randomized run against an array-based model.
module tb_register_file_multiport;
    localparam int ND = 3;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic [ND-1:0] sw;
    logic [4:0]    wa [ND];
    logic [31:0]   nv [ND];
    logic [4:0]    ra [ND];
    logic [4:0]    rb [ND];
    logic [15:0]   a0, b0, a1, b1;
    logic [31:0]   a2, b2;
    logic [ND-1:0] rdy;
    logic [ND-1:0] drp;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // dut0: defaults (INIT 1, bypass); dut1: INIT 3, zero reg, no bypass; dut2: 32x32, INIT 0
    register_file_multiport #(.WIDTH(16), .ADDR_W(3), .RESET_VALUE(16'h0000), .INIT_CYCLES(1),
        .ZERO_REG(1'b0), .BYPASS(1'b1)) dut0 (
        .clock(clock), .reset_n(reset_n), .should_write(sw[0]), .write_addr(wa[0][2:0]),
        .new_value(nv[0][15:0]), .read_addr_a(ra[0][2:0]), .read_value_a(a0),
        .read_addr_b(rb[0][2:0]), .read_value_b(b0), .ready(rdy[0]), .write_dropped(drp[0]));
    register_file_multiport #(.WIDTH(16), .ADDR_W(3), .RESET_VALUE(16'h0000), .INIT_CYCLES(3),
        .ZERO_REG(1'b1), .BYPASS(1'b0)) dut1 (
        .clock(clock), .reset_n(reset_n), .should_write(sw[1]), .write_addr(wa[1][2:0]),
        .new_value(nv[1][15:0]), .read_addr_a(ra[1][2:0]), .read_value_a(a1),
        .read_addr_b(rb[1][2:0]), .read_value_b(b1), .ready(rdy[1]), .write_dropped(drp[1]));
    register_file_multiport #(.WIDTH(32), .ADDR_W(5), .RESET_VALUE(32'h0000_0000), .INIT_CYCLES(0),
        .ZERO_REG(1'b0), .BYPASS(1'b1)) dut2 (
        .clock(clock), .reset_n(reset_n), .should_write(sw[2]), .write_addr(wa[2]),
        .new_value(nv[2]), .read_addr_a(ra[2]), .read_value_a(a2),
        .read_addr_b(rb[2]), .read_value_b(b2), .ready(rdy[2]), .write_dropped(drp[2]));

    function automatic int cfg_init(int d);
        case (d)
            0: return 1;
            1: return 3;
            default: return 0;
        endcase
    endfunction
    function automatic bit cfg_zero(int d);   return (d == 1); endfunction
    function automatic bit cfg_byp(int d);    return (d != 1); endfunction
    function automatic int cfg_depth(int d);  return (d == 2) ? 32 : 8; endfunction
    function automatic logic [31:0] cfg_mask(int d);
        return (d == 2) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    endfunction

    function automatic logic [31:0] got_a(int d);
        case (d)
            0: return {16'h0000, a0};
            1: return {16'h0000, a1};
            default: return a2;
        endcase
    endfunction
    function automatic logic [31:0] got_b(int d);
        case (d)
            0: return {16'h0000, b0};
            1: return {16'h0000, b1};
            default: return b2;
        endcase
    endfunction

    // Reference model: plain arrays plus a count of posedges since reset release
    logic [31:0]   mem_m [ND][32];
    int            since_m [ND];
    logic [ND-1:0] drop_m;

    function automatic bit ready_m(int d);
        return since_m[d] >= cfg_init(d);
    endfunction
    function automatic bit accept_m(int d);
        return sw[d] && ready_m(d) && !(cfg_zero(d) && wa[d] == 5'd0);
    endfunction
    function automatic logic [31:0] read_m(int d, logic [4:0] addr);
        if (cfg_zero(d) && addr == 5'd0) return 32'h0;
        if (cfg_byp(d) && accept_m(d) && addr == wa[d]) return nv[d] & cfg_mask(d);
        return mem_m[d][addr];
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int d = 0; d < ND; d++) begin
                for (int i = 0; i < 32; i++) mem_m[d][i] <= 32'h0;
                since_m[d] <= 0;
                drop_m[d]  <= 1'b0;
            end
        end else begin
            for (int d = 0; d < ND; d++) begin
                drop_m[d] <= sw[d] && !accept_m(d);
                if (accept_m(d)) mem_m[d][wa[d]] <= nv[d] & cfg_mask(d);
                if (since_m[d] < 1000) since_m[d] <= since_m[d] + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Continuous comparison of every instance against the model, away from the active edge
    always @(negedge clock) begin
        if (chk_en) begin
            for (int d = 0; d < ND; d++) begin
                check($sformatf("model_rd_a[%0d]", d), got_a(d), read_m(d, ra[d]));
                check($sformatf("model_rd_b[%0d]", d), got_b(d), read_m(d, rb[d]));
                check($sformatf("model_ready[%0d]", d), {31'h0, rdy[d]}, {31'h0, ready_m(d)});
                check($sformatf("model_drop[%0d]", d), {31'h0, drp[d]}, {31'h0, drop_m[d]});
            end
        end
    end

    typedef struct {
        logic        sw;
        logic [2:0]  wa;
        logic [15:0] nv;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [15:0] ea;
        logic [15:0] eb;
        logic        er;
        logic        ed;
    } vec_t;

    vec_t vecs [7];

    initial begin
        // dut0 from reset release: guard, bypass on both ports, then plain reads
        vecs[0] = '{1'b1, 3'd2, 16'hBEEF, 3'd2, 3'd2, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 3'd2, 16'hBEEF, 3'd2, 3'd3, 16'hBEEF, 16'h0000, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 3'd0, 16'h0000, 3'd2, 3'd2, 16'hBEEF, 16'hBEEF, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 3'd5, 16'h1234, 3'd5, 3'd5, 16'h1234, 16'h1234, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 3'd0, 16'h0000, 3'd5, 3'd2, 16'h1234, 16'hBEEF, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd7, 16'hFFFF, 16'h0000, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 3'd0, 16'h0000, 3'd0, 3'd5, 16'hFFFF, 16'h1234, 1'b1, 1'b0};

        sw = '0;
        for (int d = 0; d < ND; d++) begin
            wa[d] = 5'd0; nv[d] = 32'h0; ra[d] = 5'd0; rb[d] = 5'd0;
        end
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b1;
        chk_en = 1'b1;

        for (int i = 0; i < 7; i++) begin
            sw[0] = vecs[i].sw;
            wa[0] = {2'b00, vecs[i].wa};
            nv[0] = {16'h0000, vecs[i].nv};
            ra[0] = {2'b00, vecs[i].ra};
            rb[0] = {2'b00, vecs[i].rb};
            @(negedge clock);
            check($sformatf("vec%0d_rd_a", i), {16'h0, a0}, {16'h0, vecs[i].ea});
            check($sformatf("vec%0d_rd_b", i), {16'h0, b0}, {16'h0, vecs[i].eb});
            check($sformatf("vec%0d_ready", i), {31'h0, rdy[0]}, {31'h0, vecs[i].er});
            check($sformatf("vec%0d_drop", i), {31'h0, drp[0]}, {31'h0, vecs[i].ed});
            @(posedge clock); #1;
        end
        sw[0] = 1'b0;

        // dut1: zero register ignores writes, entry 7 does not, no bypass
        sw[1] = 1'b1; wa[1] = 5'd0; nv[1] = 32'hFFFF; ra[1] = 5'd0; rb[1] = 5'd0;
        @(negedge clock);
        check("zero_rd_same_cycle", {16'h0, a1}, 32'h0);
        @(posedge clock); #1;
        check("zero_drop", {31'h0, drp[1]}, 32'h1);
        check("zero_rd_after", {16'h0, a1}, 32'h0);
        wa[1] = 5'd7; ra[1] = 5'd7;
        @(negedge clock);
        check("nobyp_old_val", {16'h0, a1}, 32'h0);
        @(posedge clock); #1;
        check("r7_drop", {31'h0, drp[1]}, 32'h0);
        check("r7_rd_after", {16'h0, a1}, 32'hFFFF);
        wa[1] = 5'd5; nv[1] = 32'h1234; ra[1] = 5'd5; rb[1] = 5'd5;
        @(negedge clock);
        check("nobyp_a_old", {16'h0, a1}, 32'h0);
        check("nobyp_b_old", {16'h0, b1}, 32'h0);
        @(posedge clock); #1;
        sw[1] = 1'b0;
        #1;
        check("nobyp_a_new", {16'h0, a1}, 32'h1234);
        check("nobyp_b_new", {16'h0, b1}, 32'h1234);
        @(posedge clock); #1;

        // dut0 fill, then asynchronous reset between edges
        for (int i = 0; i < 8; i++) begin
            sw[0] = 1'b1; wa[0] = 5'(i); nv[0] = 32'h0011 * (i + 1);
            @(posedge clock); #1;
        end
        sw[0] = 1'b0; ra[0] = 5'd3; rb[0] = 5'd7;
        #1;
        check("fill_rd3", {16'h0, a0}, 32'h0044);
        check("fill_rd7", {16'h0, b0}, 32'h0088);
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ra[0] = 5'(2 * i); rb[0] = 5'(2 * i + 1);
            #1;
            check($sformatf("rst_rd_a%0d", 2 * i), {16'h0, a0}, 32'h0);
            check($sformatf("rst_rd_b%0d", 2 * i + 1), {16'h0, b0}, 32'h0);
        end
        check("rst_ready0", {31'h0, rdy[0]}, 32'h0);
        check("rst_ready2", {31'h0, rdy[2]}, 32'h1);
        sw[1] = 1'b1; wa[1] = 5'd3; nv[1] = 32'hA001; ra[1] = 5'd3;
        @(posedge clock);
        #2 reset_n = 1'b1;
        #1;
        check("rel_ready0", {31'h0, rdy[0]}, 32'h0);
        check("rel_ready2", {31'h0, rdy[2]}, 32'h1);
        for (int k = 1; k <= 4; k++) begin
            nv[1] = 32'hA000 + k;
            @(posedge clock); #1;
            check($sformatf("guard_drop%0d", k), {31'h0, drp[1]}, (k <= 3) ? 32'h1 : 32'h0);
        end
        sw[1] = 1'b0;
        #1;
        check("guard_first_accept", {16'h0, a1}, 32'hA004);

        // dut2: wide/deep configuration, extreme addresses, no aliasing
        sw[2] = 1'b1; wa[2] = 5'd31; nv[2] = 32'hDEAD_BEEF;
        @(posedge clock); #1;
        wa[2] = 5'd0; nv[2] = 32'hCAFE_F00D;
        @(posedge clock); #1;
        sw[2] = 1'b0; ra[2] = 5'd31; rb[2] = 5'd0;
        #1;
        check("wide_rd31", a2, 32'hDEAD_BEEF);
        check("wide_rd0", b2, 32'hCAFE_F00D);
        ra[2] = 5'd15; rb[2] = 5'd16;
        #1;
        check("wide_alias15", a2, 32'h0);
        check("wide_alias16", b2, 32'h0);
        @(posedge clock); #1;

        // Randomized traffic on all three instances, with one mid-run reset
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int d = 0; d < ND; d++) begin
                sw[d] = ($urandom_range(0, 3) != 0);
                wa[d] = 5'($urandom_range(0, cfg_depth(d) - 1));
                nv[d] = $urandom & cfg_mask(d);
                ra[d] = ($urandom_range(0, 2) == 0) ? wa[d] : 5'($urandom_range(0, cfg_depth(d) - 1));
                rb[d] = ($urandom_range(0, 2) == 0) ? wa[d] : 5'($urandom_range(0, cfg_depth(d) - 1));
            end
            if (cyc == 200) begin
                #1 reset_n = 1'b0;
                @(posedge clock);
                #2 reset_n = 1'b1;
            end
            @(posedge clock); #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/register_file_multiport.md
# register_file_multiport

Parametrised register file: 2^ADDR_W entries of WIDTH bits, one synchronous write port and two combinational read ports. Generalises the single 16-bit write-enabled register: configurable width and depth, asynchronous reset, a multi-cycle post-reset write guard, an optional hardwired zero register, and optional write-to-read bypass. It serves as the general-purpose register bank of the datapath, between the decode stage (read addresses) and the write-back stage (write port).

## Interface
- WIDTH, 16, bits per entry
- ADDR_W, 3, address width; DEPTH = 2^ADDR_W entries
- RESET_VALUE, 0, value loaded into every entry on reset
- INIT_CYCLES, 1, clock posedges after reset release during which writes are discarded; 0 = none
- ZERO_REG, 0, 1 = entry 0 always reads 0 and ignores writes
- BYPASS, 1, 1 = a read of the address being written this cycle returns new_value

- clock  input  1  single clock; all state updates on posedge
- reset_n  input  1  asynchronous, active-low reset
- should_write  input  1  write request for this cycle
- write_addr  input  ADDR_W  write target entry
- new_value  input  WIDTH  write data
- read_addr_a  input  ADDR_W  read port A address
- read_value_a  output  WIDTH  read port A data (combinational)
- read_addr_b  input  ADDR_W  read port B address
- read_value_b  output  WIDTH  read port B data (combinational)
- ready  output  1  1 when writes are accepted
- write_dropped  output  1  registered one-cycle pulse: the previous cycle's write request was discarded

## Operation
- Reset (reset_n=0, asynchronous): every entry = RESET_VALUE; init counter = 0; ready = 0 (1 if INIT_CYCLES=0); write_dropped = 0.
- Init guard: after reset release, the counter increments on each posedge until it equals INIT_CYCLES, then holds. ready = (counter == INIT_CYCLES). Counter width = clog2(INIT_CYCLES+1), min 1 bit.
- Write accepted at posedge iff should_write=1, ready=1, and not (ZERO_REG=1 and write_addr=0). Accepted: entry[write_addr] <= new_value. Otherwise the array is unchanged.
- write_dropped <= should_write & ~accepted on every posedge; the zero-register case counts as dropped.
- Read (per port, purely combinational):
  - ZERO_REG=1 and addr=0: 0.
  - else BYPASS=1 and the current-cycle write is accepted and addr=write_addr: new_value.
  - else entry[addr].
- Both ports may read the same address; either may match the write address; both are bypassed independently.
- Reset asserted mid-operation: all state clears immediately; the guard restarts from 0 after release.

## Timing
- Write latency: data visible on the non-bypassed read path in the cycle after the accepting posedge; on the bypassed path combinationally, same cycle.
- With INIT_CYCLES=N: ready rises after the Nth posedge following reset release. The first accepted write is at posedge N+1 after release.
- write_dropped is high for exactly the cycle after a discarded request. Back-to-back discarded requests keep it high continuously.
- No read-side state: read outputs change only from address, array, or bypass changes. No read latency.
- The 16-bit, INIT_CYCLES=1, ZERO_REG=0, BYPASS=0 configuration matches the legacy single-register behaviour: the first-cycle write is ignored and data is visible the next cycle.

## Test plan
- Reset then guard: reset_n low, then release; should_write=1, write_addr=2, new_value=0xBEEF held through the first posedge -> entry 2 stays 0x0000, write_dropped=1 next cycle, ready=1 after posedge 1. Second posedge -> entry 2 = 0xBEEF.
- Dual-port read and bypass (BYPASS=1): write 0x1234 to addr 5 while read_addr_a=5, read_addr_b=5 -> both ports show 0x1234 in the same cycle. With BYPASS=0 -> both show the old value until after the posedge.
- Zero register (ZERO_REG=1): write 0xFFFF to addr 0 -> reads 0x0000, write_dropped=1. Write 0xFFFF to addr 7 -> reads 0xFFFF, write_dropped=0.
- Asynchronous reset mid-stream: fill entries 0..7 with 0x0011..0x0088, assert reset_n between edges -> all reads 0x0000 immediately, ready=0. After release, INIT_CYCLES=3 -> three writes dropped, fourth accepted.
- Width/depth sweep: WIDTH=32, ADDR_W=5, INIT_CYCLES=0 -> ready=1 right after release. Write 0xDEADBEEF to addr 31 and 0xCAFEF00D to addr 0 on consecutive cycles -> both read back exactly; no aliasing between addresses.
